// File: rtl/fetch_pcreg.sv
// Fetch PC register: issues one instruction-bus request at a time and hands the word to decode.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned PC skips the bus and delivers a zero word with out_adel set.
module fetch_pcreg #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_selected,
  input  logic        pc_redirect,
  output logic [31:0] pc,
  output logic [31:0] pc_succ,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t            state_q, state_nx;
  logic [XLEN-1:0]   pc_q, pc_nx;
  logic [XLEN-1:0]   buf_q, buf_nx;
  logic              adel_q, adel_nx;
  logic              ireq_valid_q, ireq_valid_nx;
  logic              out_valid_q, out_valid_nx;
  logic              misalign;
  logic              misalign_nx;

  // Address-error detection on the current and the upcoming PC.
  always_comb begin
    misalign    = 1'b0;
    misalign_nx = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign    = (pc_q[1:0]  != 2'b00);
    misalign_nx = (pc_nx[1:0] != 2'b00);
`endif
  end

  // Next-state, next-PC and buffer update.
  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    buf_nx   = buf_q;
    adel_nx  = adel_q;

    // A redirect always loads the PC, whatever else happens this cycle.
    if (pc_redirect) begin
      pc_nx = pc_selected;
    end

    case (state_q)
      S_REQ: begin
        if (pc_redirect) begin
          // A misaligned PC never raised ireq_valid, so an addr_ok then is meaningless.
          state_nx = (ireq_addr_ok && !misalign) ? S_DROP : S_REQ;
        end else if (misalign) begin
          state_nx = S_VALID;
          buf_nx   = '0;
          adel_nx  = 1'b1;
        end else if (ireq_addr_ok) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_data_ok) begin
          if (pc_redirect) begin
            state_nx = S_REQ;
          end else begin
            state_nx = S_VALID;
            buf_nx   = iresp_data;
            adel_nx  = 1'b0;
          end
        end else if (pc_redirect) begin
          state_nx = S_DROP;
        end
      end
      S_VALID: begin
        if (out_ready || pc_redirect) begin
          state_nx = S_REQ;
          pc_nx    = pc_selected;
          adel_nx  = 1'b0;
        end
      end
      S_DROP: begin
        if (iresp_data_ok) begin
          state_nx = S_REQ;
        end
      end
      default: begin
        state_nx = S_REQ;
      end
    endcase

    ireq_valid_nx = (state_nx == S_REQ) && !misalign_nx;
    out_valid_nx  = (state_nx == S_VALID);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      buf_q        <= '0;
      adel_q       <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      ireq_valid_q <= (RESET_PC[1:0] == 2'b00);
`else
      ireq_valid_q <= 1'b1;
`endif
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_nx;
      pc_q         <= pc_nx;
      buf_q        <= buf_nx;
      adel_q       <= adel_nx;
      ireq_valid_q <= ireq_valid_nx;
      out_valid_q  <= out_valid_nx;
    end
  end

  assign pc         = pc_q;
  assign pc_succ    = pc_q + 32'd4;
  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = pc_q;
  assign out_instr  = buf_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign out_adel   = adel_q;
`else
  assign out_adel   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pcreg.sv
// Bench for fetch_pcreg: directed bus/decode stimulus with a delivery scoreboard.
module tb_fetch_pcreg;

  logic        clk;
  logic        resetn;
  logic [31:0] pc_selected;
  logic        pc_redirect;
  logic [31:0] pc;
  logic [31:0] pc_succ;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } deliv_t;

  deliv_t sb[$];
  int     vec_cnt = 0;
  int     err_cnt = 0;

  fetch_pcreg #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pc_selected   (pc_selected),
    .pc_redirect   (pc_redirect),
    .pc            (pc),
    .pc_succ       (pc_succ),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_addr_ok  (ireq_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_adel      (out_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Score a handshake that will complete at the coming edge, then advance one cycle.
  task automatic step();
    deliv_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", out_pc, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_adel", 32'(out_adel), 32'(e.adel));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ireq_addr_ok  = 1'b0;
    iresp_data_ok = 1'b0;
    pc_redirect   = 1'b0;
    out_ready     = 1'b0;
  endtask

  // Plain fetch from REQ to VALID at the given address.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input logic push);
    deliv_t e;
    check("fetch_req_v", 32'(ireq_valid), 32'd1);
    check("fetch_req_a", ireq_addr, addr);
    if (push) begin
      e.pc = addr; e.instr = word; e.adel = 1'b0;
      sb.push_back(e);
    end
    idle();
    ireq_addr_ok = 1'b1;
    step();
    idle();
    iresp_data_ok = 1'b1;
    iresp_data    = word;
    step();
    idle();
    check("fetch_out_v", 32'(out_valid), 32'd1);
    check("fetch_out_i", out_instr, word);
  endtask

  initial begin
    deliv_t e;
    resetn      = 1'b0;
    pc_selected = 32'h0;
    iresp_data  = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'hbfc0_0000);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_adel", 32'(out_adel), 32'd0);
    resetn = 1'b1;
    step();
    check("rel_ireq_valid", 32'(ireq_valid), 32'd1);
    check("rel_ireq_addr", ireq_addr, 32'hbfc0_0000);
    check("rel_pc_succ", pc_succ, 32'hbfc0_0004);

    // First fetch with minimum latency.
    e.pc = 32'hbfc0_0000; e.instr = 32'h2408_0001; e.adel = 1'b0;
    sb.push_back(e);
    ireq_addr_ok = 1'b1;
    pc_selected  = 32'hbfc0_0004;
    step();
    idle();
    check("wait_ireq_valid", 32'(ireq_valid), 32'd0);
    check("wait_out_valid", 32'(out_valid), 32'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2408_0001;
    step();
    idle();
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_pc", out_pc, 32'hbfc0_0000);
    check("lat_out_instr", out_instr, 32'h2408_0001);

    // Decode stall keeps everything stable.
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_pc", out_pc, 32'hbfc0_0000);
      check("stall_out_instr", out_instr, 32'h2408_0001);
      check("stall_ireq_valid", 32'(ireq_valid), 32'd0);
    end
    out_ready = 1'b1;
    step();
    idle();
    check("acc_out_valid", 32'(out_valid), 32'd0);
    check("acc_ireq_valid", 32'(ireq_valid), 32'd1);
    check("acc_ireq_addr", ireq_addr, 32'hbfc0_0004);

    // Redirect while waiting for data: the late word is discarded.
    ireq_addr_ok = 1'b1;
    pc_selected  = 32'hbfc0_0008;
    step();
    idle();
    pc_redirect = 1'b1;
    pc_selected = 32'h8000_0180;
    step();
    idle();
    check("wredir_pc", pc, 32'h8000_0180);
    check("wredir_ireq_valid", 32'(ireq_valid), 32'd0);
    step();
    step();
    check("drop_out_valid", 32'(out_valid), 32'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdead_beef;
    step();
    idle();
    check("drop_done_out_valid", 32'(out_valid), 32'd0);
    check("drop_done_ireq_valid", 32'(ireq_valid), 32'd1);
    check("drop_done_ireq_addr", ireq_addr, 32'h8000_0180);

    // Redirect coincident with data_ok.
    ireq_addr_ok = 1'b1;
    pc_selected  = 32'h8000_0184;
    step();
    idle();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1111_1111;
    pc_redirect   = 1'b1;
    pc_selected   = 32'h8000_0200;
    step();
    idle();
    check("dredir_out_valid", 32'(out_valid), 32'd0);
    check("dredir_ireq_valid", 32'(ireq_valid), 32'd1);
    check("dredir_ireq_addr", ireq_addr, 32'h8000_0200);

    // Redirect coincident with addr_ok.
    ireq_addr_ok = 1'b1;
    pc_redirect  = 1'b1;
    pc_selected  = 32'h8000_0300;
    step();
    idle();
    check("aredir_ireq_valid", 32'(ireq_valid), 32'd0);
    check("aredir_pc", pc, 32'h8000_0300);
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2222_2222;
    step();
    idle();
    check("aredir_out_valid", 32'(out_valid), 32'd0);

    // Redirect together with out_ready still delivers the word.
    fetch(32'h8000_0300, 32'h3333_3333, 1'b1);
    out_ready   = 1'b1;
    pc_redirect = 1'b1;
    pc_selected = 32'h9000_0000;
    step();
    idle();
    check("vredir_ireq_addr", ireq_addr, 32'h9000_0000);

    // Redirect without out_ready: word is not delivered.
    fetch(32'h9000_0000, 32'h4444_4444, 1'b0);
    pc_redirect = 1'b1;
    pc_selected = 32'h9000_0010;
    step();
    idle();
    check("vdrop_out_valid", 32'(out_valid), 32'd0);
    check("vdrop_ireq_addr", ireq_addr, 32'h9000_0010);

    // Redirect in REQ without addr_ok withdraws the request.
    pc_redirect = 1'b1;
    pc_selected = 32'hffff_fffc;
    step();
    idle();
    check("rredir_ireq_valid", 32'(ireq_valid), 32'd1);
    check("rredir_ireq_addr", ireq_addr, 32'hffff_fffc);
    check("wrap_pc_succ", pc_succ, 32'h0000_0000);

    // Misaligned PC.
    pc_redirect = 1'b1;
    pc_selected = 32'hbfc0_0002;
    step();
    idle();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_ireq_valid", 32'(ireq_valid), 32'd0);
    e.pc = 32'hbfc0_0002; e.instr = 32'h0; e.adel = 1'b1;
    sb.push_back(e);
    ireq_addr_ok = 1'b1;
    step();
    idle();
    check("mis_out_valid", 32'(out_valid), 32'd1);
    check("mis_out_adel", 32'(out_adel), 32'd1);
    check("mis_out_instr", out_instr, 32'h0);
    check("mis_out_pc", out_pc, 32'hbfc0_0002);
    out_ready   = 1'b1;
    pc_selected = 32'hbfc0_0008;
    step();
    idle();
    check("mis_adel_clr", 32'(out_adel), 32'd0);
    check("mis_next_req", 32'(ireq_valid), 32'd1);
    check("mis_next_addr", ireq_addr, 32'hbfc0_0008);
`else
    check("mis_out_adel0", 32'(out_adel), 32'd0);
    fetch(32'hbfc0_0002, 32'h5555_5555, 1'b1);
    check("mis_out_adel1", 32'(out_adel), 32'd0);
    out_ready   = 1'b1;
    pc_selected = 32'hbfc0_0006;
    step();
    idle();
    check("mis_next_addr", ireq_addr, 32'hbfc0_0006);
`endif

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_pcreg.md
Name: fetch_pcreg

Overview:
- Holds the architectural fetch PC and drives the instruction-bus request for it.
- Returns fetched instructions to decode through a valid/ready handshake.
- Feeds pc_succ to the upstream PC-select logic and consumes that logic's pc_selected as the next PC.
- Sits between PC select and decode; discards in-flight fetches when a redirect occurs.

Parameters:
RESET_PC, 32'hbfc0_0000, PC loaded on reset

Ports:
clk  in  1  the single clock
resetn  in  1  reset: asynchronous assertion, active-low
pc_selected  in  32  next PC chosen by the PC-select stage
pc_redirect  in  1  pc_selected is non-sequential (branch/exception/eret/refetch); squash current fetch
pc  out  32  current fetch PC
pc_succ  out  32  pc + 4, combinational
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  32  request address
ireq_addr_ok  in  1  bus accepted request this cycle
iresp_data_ok  in  1  response data valid this cycle
iresp_data  in  32  instruction word
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts this cycle
out_pc  out  32  PC of delivered instruction
out_instr  out  32  delivered instruction
out_adel  out  1  address-error flag for delivered instruction

Behaviour:
- Reset (resetn=0, asynchronous): pc=RESET_PC, state=REQ, instruction buffer=0, adel=0. Outputs: out_valid=0, out_instr=0, out_adel=0, ireq_valid=1 after release.
- pc_succ = pc + 4, modulo 2^32 (0xffff_fffc wraps to 0).
- One outstanding request maximum. data_ok never arrives in the same cycle as its addr_ok.
- FSM states REQ, WAIT, VALID, DROP:
  - REQ: ireq_valid=1, ireq_addr=pc.
    - addr_ok & !pc_redirect -> WAIT.
    - addr_ok & pc_redirect -> DROP; pc<=pc_selected.
    - !addr_ok & pc_redirect -> REQ; pc<=pc_selected. Request is withdrawn; the new address is presented next cycle.
  - WAIT: ireq_valid=0.
    - data_ok & !pc_redirect -> VALID; buffer<=iresp_data.
    - data_ok & pc_redirect -> REQ; data dropped; pc<=pc_selected.
    - !data_ok & pc_redirect -> DROP; pc<=pc_selected.
  - VALID: out_valid=1, out_pc=pc, out_instr=buffer, ireq_valid=0.
    - out_ready & !pc_redirect -> REQ; pc<=pc_selected.
    - pc_redirect (with or without out_ready) -> REQ; pc<=pc_selected. The instruction counts as not delivered unless out_ready was high.
  - DROP: ireq_valid=0, out_valid=0.
    - data_ok -> REQ; data discarded.
    - pc_redirect while in DROP: pc<=pc_selected; stay DROP until data_ok.
- pc changes only on the transitions listed above; otherwise it holds.
- Minimum latency: REQ with addr_ok at cycle t, data_ok at t+1, out_valid at t+2. Best throughput is one instruction per 3 cycles.
- out_valid is a registered state decode; it never depends combinationally on out_ready.
- pc_redirect outside the cases above has no effect beyond loading pc.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: in REQ with pc[1:0]!=0, ireq_valid=0. Next state is VALID with buffer=0 and adel=1, so out_adel=1 while in VALID; adel clears on leaving VALID. pc_redirect in that REQ cycle overrides (normal REQ redirect rule).
- Undefined: no check. ireq_addr=pc unchanged, out_adel tied 0.

Test Plan:
- Reset release, addr_ok on the first REQ cycle, data_ok=1 with 0x2408_0001 the next cycle, out_ready=1: ireq_addr=0xbfc0_0000; out_valid two cycles after accept; out_pc=0xbfc0_0000, out_instr=0x2408_0001; next ireq_addr=pc_selected (0xbfc0_0004).
- Decode stall: out_ready=0 for 5 cycles in VALID -> out_valid/out_pc/out_instr stable; no ireq_valid; pc unchanged.
- Redirect in WAIT: pc_redirect=1, pc_selected=0x8000_0180, data_ok arrives 3 cycles later -> state DROP; that data is never delivered; next request addr 0x8000_0180.
- Redirect coincident with data_ok in WAIT -> no out_valid; next cycle REQ at pc_selected.
- Redirect coincident with addr_ok in REQ -> DROP; the returned word is discarded; request then issued to pc_selected.
- With FETCH_ALIGN_CHECK_EN, pc_selected=0xbfc0_0002 -> no bus request; out_valid=1, out_adel=1, out_instr=0, out_pc=0xbfc0_0002. Without the macro, ireq_addr=0xbfc0_0002 and out_adel=0.
